// File: rtl/obstacle_field.sv
// obstacle_field: scrolling obstacle slots with sprite ROM, pixel output, spawn pacing and collision flag
module obstacle_field #(
    parameter int N_SLOTS  = 3,
    parameter int SPR_W    = 60,
    parameter int SPR_H    = 58,
    parameter int Y_TOP    = 344,
    parameter int SCREEN_W = 640,
    parameter int MIN_GAP  = 200
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        game_status,
    input  logic        fresh,
    input  logic [3:0]  speed,
    input  logic        dino_px,
    output logic        px,
    output logic        collide,
    output logic [15:0] passed_cnt
);

    // Fixed cactus bitmap: trunk with clipped top corners, a low left arm and a high right arm.
    function automatic logic rom_bit(input int r, input int c);
        return (c >= SPR_W*2/5 && c < SPR_W*3/5 && !(r < 2 && (c == SPR_W*2/5 || c == SPR_W*3/5-1)))
            || (c >= SPR_W/10 && c < SPR_W/4 && r >= SPR_H/5 && r < SPR_H*3/5)
            || (c >= SPR_W/10 && c < SPR_W*2/5 && r >= SPR_H/2 && r < SPR_H*3/5)
            || (c >= SPR_W*3/4 && c < SPR_W*9/10 && r >= SPR_H/10 && r < SPR_H/2)
            || (c >= SPR_W*3/5 && c < SPR_W*9/10 && r >= SPR_H*2/5 && r < SPR_H/2);
    endfunction

    logic [N_SLOTS-1:0] active;
    logic [10:0]        pos [N_SLOTS];
    logic [10:0]        gap_cnt;
    logic [7:0]         lfsr;
    logic               fresh_q;
    logic               tick;
    logic               obs;
    logic               spawn;
    logic               has_free;
    logic [N_SLOTS-1:0] retire;
    int                 free_idx;
    int                 n_ret;
    int                 rr;
    int                 cc;
    logic [10:0]        gap_next;
    logic [15:0]        passed_next;

    assign tick = fresh_q & ~fresh & game_status;

    // Per-slot hit test, retirement, free-slot pick and the next counter values, all from pre-tick state.
    always_comb begin
        obs      = 1'b0;
        retire   = '0;
        has_free = 1'b0;
        free_idx = 0;
        n_ret    = 0;
        rr       = int'(row_addr) - Y_TOP;
        cc       = 0;
        for (int i = 0; i < N_SLOTS; i++) begin
            cc        = int'(col_addr) - (SCREEN_W - int'(pos[i]));
            obs       = obs | (active[i] && int'(col_addr) < SCREEN_W && rr >= 0 && rr < SPR_H
                               && cc >= 0 && cc < SPR_W && rom_bit(rr, cc));
            retire[i] = active[i] && int'(pos[i]) + int'(speed) >= SCREEN_W + SPR_W;
            n_ret     = n_ret + int'(retire[i]);
            if (!active[i] && !has_free) begin
                has_free = 1'b1;
                free_idx = i;
            end
        end
        spawn       = has_free && int'(gap_cnt) >= MIN_GAP + int'(lfsr[6:0]);
        gap_next    = spawn ? '0 : (int'(gap_cnt) + int'(speed) > 2047 ? 11'h7FF : gap_cnt + 11'(speed));
        passed_next = int'(passed_cnt) + n_ret > 65535 ? 16'hFFFF : passed_cnt + 16'(n_ret);
    end

    // Registered pixel/collision outputs and the once-per-running-tick slot, gap and LFSR update.
    always_ff @(posedge clk) begin
        if (RESET) begin
            px         <= 1'b0;
            collide    <= 1'b0;
            passed_cnt <= '0;
            active     <= '0;
            for (int i = 0; i < N_SLOTS; i++) pos[i] <= '0;
            gap_cnt    <= 11'(MIN_GAP);
            lfsr       <= 8'hA5;
            fresh_q    <= 1'b0;
        end else begin
            fresh_q <= fresh;
            px      <= obs;
            collide <= collide | (obs & dino_px & game_status);
            if (tick) begin
                lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                gap_cnt    <= gap_next;
                passed_cnt <= passed_next;
                for (int i = 0; i < N_SLOTS; i++) begin
                    if (spawn && i == free_idx) begin
                        active[i] <= 1'b1;
                        pos[i]    <= '0;
                    end else if (active[i]) begin
                        active[i] <= ~retire[i];
                        pos[i]    <= pos[i] + 11'(speed);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field: randomized frames checked every cycle against a behavioural model, plus literal checkpoints
module tb_obstacle_field;
    localparam int NS = 3, W = 60, H = 58, YT = 344, SW = 640, MG = 200;

    logic        clk = 0, RESET = 1, game_status = 0, fresh = 0, dino_px = 0;
    logic [8:0]  row_addr = 0;
    logic [9:0]  col_addr = 0;
    logic [3:0]  speed = 0;
    logic        px, collide;
    logic [15:0] passed_cnt;

    int errors = 0, checks = 0;

    bit m_act [NS];
    int m_pos [NS];
    int m_gap, m_lfsr, m_passed;
    bit m_fq, e_px, e_col, m_valid = 0;

    always #5 clk = ~clk;

    obstacle_field dut (
        .clk(clk), .RESET(RESET), .row_addr(row_addr), .col_addr(col_addr),
        .game_status(game_status), .fresh(fresh), .speed(speed), .dino_px(dino_px),
        .px(px), .collide(collide), .passed_cnt(passed_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sprite as a list of filled rectangles {r0, r1, c0, c1} (half-open).
    function automatic bit rom(int r, int c);
        int rect [6][4] = '{'{0, 2, 25, 35}, '{2, 58, 24, 36}, '{11, 34, 6, 15},
                            '{29, 34, 6, 24}, '{5, 29, 45, 54}, '{23, 29, 36, 54}};
        for (int k = 0; k < 6; k++)
            if (r >= rect[k][0] && r < rect[k][1] && c >= rect[k][2] && c < rect[k][3]) return 1;
        return 0;
    endfunction

    function automatic bit model_obs(int row, int col);
        if (col >= SW) return 0;
        for (int i = 0; i < NS; i++)
            if (m_act[i] && row - YT >= 0 && row - YT < H && col - (SW - m_pos[i]) >= 0
                && col - (SW - m_pos[i]) < W && rom(row - YT, col - (SW - m_pos[i]))) return 1;
        return 0;
    endfunction

    task automatic model_tick();
        int fr = -1;
        bit want;
        for (int i = 0; i < NS; i++) if (!m_act[i] && fr < 0) fr = i;
        want = m_gap >= MG + (m_lfsr % 128);
        for (int i = 0; i < NS; i++)
            if (m_act[i]) begin
                m_pos[i] += int'(speed);
                if (m_pos[i] >= SW + W) begin
                    m_act[i] = 0;
                    if (m_passed < 65535) m_passed++;
                end
            end
        m_gap = (m_gap + int'(speed) > 2047) ? 2047 : m_gap + int'(speed);
        if (want && fr >= 0) begin
            m_act[fr] = 1;
            m_pos[fr] = 0;
            m_gap = 0;
        end
        m_lfsr = ((m_lfsr << 1) & 255) | ($countones(m_lfsr & 8'hB8) & 1);
    endtask

    always @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_pos[i] = 0; end
            m_gap = MG; m_lfsr = 8'hA5; m_passed = 0; m_fq = 0; e_px = 0; e_col = 0;
            m_valid = 1;
        end else begin
            bit o, tk;
            o = model_obs(int'(row_addr), int'(col_addr));
            e_col = e_col | (o & dino_px & game_status);
            e_px = o;
            tk = m_fq && !fresh;
            m_fq = fresh;
            if (tk && game_status) model_tick();
        end
    end

    always @(negedge clk)
        if (m_valid) begin
            check("px", px, e_px);
            check("collide", collide, e_col);
            check("passed_cnt", passed_cnt, m_passed);
        end

    task automatic cyc(input int r, input int c);
        @(negedge clk);
        row_addr = 9'(r);
        col_addr = 10'(c);
    endtask

    task automatic rnd_cyc(input bit f);
        int m = $urandom_range(0, 9);
        cyc(m == 0 ? $urandom_range(0, 511) : $urandom_range(330, 410),
            m == 1 ? $urandom_range(0, 1023) : (m < 4 ? $urandom_range(0, 90) : $urandom_range(0, 639)));
        fresh = f;
    endtask

    task automatic frame(input int n);
        rnd_cyc(0);
        repeat (n) rnd_cyc(1);
    endtask

    task automatic find_obs(output bit ok, output int fr, output int fc);
        ok = 0; fr = 0; fc = 0;
        for (int r = YT; r < YT + H && !ok; r++)
            for (int c = 0; c < SW && !ok; c++)
                if (model_obs(r, c)) begin ok = 1; fr = r; fc = c; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bit ok;
        int fr, fc;
        repeat (3) @(negedge clk);
        RESET = 0;
        fresh = 1;
        @(posedge clk); #1;
        check("rst_px", px, 0);
        check("rst_collide", collide, 0);
        check("rst_passed", passed_cnt, 0);
        for (int r = YT - 4; r < YT + H + 4; r += 7)
            for (int c = 0; c < 1024; c += 37) begin
                cyc(r, c);
                @(posedge clk); #1;
                check("blank_px", px, 0);
            end

        game_status = 1;
        speed = 4;
        for (int k = 0; k < 300 && !m_act[0]; k++) frame(4);
        check("first_spawn", m_act[0], 1);
        repeat (10) frame(4);
        check("model_pos40", m_pos[0], 40);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < 40; c++) begin
                cyc(YT + r, 600 + c);
                @(posedge clk); #1;
                check("img_px", px, rom(r, c));
            end
        cyc(YT + 30, 630); @(posedge clk); #1; check("trunk_px", px, 1);
        cyc(YT + 20, 610); @(posedge clk); #1; check("left_arm_px", px, 1);
        cyc(YT + 20, 620); @(posedge clk); #1; check("gap_px", px, 0);
        cyc(YT, 600);      @(posedge clk); #1; check("corner_px", px, 0);

        speed = 15;
        repeat (43) frame(3);
        check("pre_retire_cnt", passed_cnt, 0);
        frame(3);
        check("retire_cnt", passed_cnt, 1);

        for (int k = 0; k < 250; k++) begin
            speed = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            game_status = ($urandom_range(0, 6) != 0);
            frame($urandom_range(2, 12));
        end
        game_status = 1;
        speed = 9;
        repeat (5) frame(6);
        game_status = 0;
        repeat (20) frame(8);
        game_status = 1;
        repeat (5) frame(6);

        for (int k = 0; k < 200; k++) begin
            find_obs(ok, fr, fc);
            if (ok) break;
            frame(3);
        end
        check("obs_found", ok, 1);
        cyc(fr, fc);
        game_status = 0; dino_px = 1;
        @(posedge clk); #1;
        check("col_frozen", collide, 0);
        cyc(0, 0);
        game_status = 1;
        @(posedge clk); #1;
        check("col_empty", collide, 0);
        cyc(fr, fc);
        @(posedge clk); #1;
        check("col_set", collide, 1);
        check("col_px", px, 1);
        dino_px = 0;
        repeat (100) frame(3);
        check("col_hold", collide, 1);

        find_obs(ok, fr, fc);
        if (ok) begin
            cyc(fr, fc);
            @(posedge clk); #1;
            check("pre_reset_px", px, 1);
        end
        @(negedge clk);
        RESET = 1;
        @(posedge clk); #1;
        check("mid_reset_px", px, 0);
        check("mid_reset_collide", collide, 0);
        check("mid_reset_passed", passed_cnt, 0);
        @(negedge clk);
        RESET = 0;
        repeat (150) begin
            speed = 4'($urandom_range(0, 15));
            frame($urandom_range(2, 6));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
